// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the 32-bit MIPS pipeline: program counter, instruction-memory
// addressing, IF/ID pipeline register, stall/redirect/halt handling and debug counters.
module instruction_fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 128,
    parameter int unsigned PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_base,
    input  logic [15:0]     branch_offset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc_plus1,
    output logic            ifid_valid,
    output logic            halted,
    output logic [31:0]     fetch_count,
    output logic [15:0]     stall_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IMEM_DEPTH);

    logic [0:0]      state;
    logic [0:0]      state_nx;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] target;
    logic            in_range;

    logic [31:0]     instr_nx;
    logic [PC_W-1:0] pp1_nx;
    logic            valid_nx;
    logic [31:0]     fetch_nx;
    logic [15:0]     stall_nx;

    // PC is a word index, so sequential fetch advances by one, wrapping mod 2^PC_W.
    assign pc_plus1 = pc + PC_W'(1);
    assign target   = branch_base + {{(PC_W-16){branch_offset[15]}}, branch_offset};
    assign in_range = (pc < PC_LIMIT);

    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = ifid_instr;
        pp1_nx   = ifid_pc_plus1;
        valid_nx = ifid_valid;
        fetch_nx = fetch_count;
        stall_nx = stall_count;

        if (branch_taken) begin
            // Redirect wins over stall and also leaves HALT; a stall here is not counted.
            state_nx = ST_RUN;
            pc_nx    = target;
            instr_nx = '0;
            pp1_nx   = '0;
            valid_nx = 1'b0;
        end else if (state == ST_RUN) begin
            if (stall) begin
                if (stall_count != '1) begin
                    stall_nx = stall_count + 16'd1;
                end
            end else if (in_range) begin
                instr_nx = imem_instr;
                pp1_nx   = pc_plus1;
                valid_nx = 1'b1;
                pc_nx    = pc_plus1;
                fetch_nx = fetch_count + 32'd1;
            end else begin
                // Ran off the end of memory: park here with a bubble until redirected.
                state_nx = ST_HALT;
                instr_nx = '0;
                pp1_nx   = '0;
                valid_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            pc            <= '0;
            ifid_instr    <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
            fetch_count   <= '0;
            stall_count   <= '0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            ifid_instr    <= instr_nx;
            ifid_pc_plus1 <= pp1_nx;
            ifid_valid    <= valid_nx;
            fetch_count   <= fetch_nx;
            stall_count   <= stall_nx;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized scoreboard bench for instruction_fetch_stage: a behavioural fetch model
// predicts PC/flags/counters each cycle and queues every instruction it expects in IF/ID.
module tb_instruction_fetch_stage;

    localparam int unsigned DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_base = '0;
    logic [15:0] branch_offset = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [DEPTH];
    logic [63:0] exp_q [$];

    // Reference state
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_valid;
    logic [31:0] m_fc;
    int          m_sc;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < DEPTH) ? mem[imem_addr[6:0]] : 32'hBAD0BAD0;

    instruction_fetch_stage #(.IMEM_DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_base(branch_base), .branch_offset(branch_offset),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural fetch rules applied to the model state for one clock edge.
    task automatic model_step(input bit r, input bit s, input bit b,
                              input logic [31:0] base, input logic [15:0] off);
        int signed soff;
        if (r) begin
            m_pc = 0; m_halt = 0; m_valid = 0; m_fc = 0; m_sc = 0;
        end else if (b) begin
            soff = int'($signed(off));
            m_pc = base + 32'(soff);
            m_halt = 0; m_valid = 0;
        end else if (m_halt) begin
            // nothing moves while halted
        end else if (s) begin
            if (m_sc < 65535) m_sc++;
        end else if (m_pc < DEPTH) begin
            exp_q.push_back({mem[m_pc[6:0]], m_pc + 32'd1});
            m_pc = m_pc + 32'd1;
            m_valid = 1;
            m_fc = m_fc + 32'd1;
        end else begin
            m_halt = 1; m_valid = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit b,
                       input logic [31:0] base, input logic [15:0] off);
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; branch_base = base; branch_offset = off;
        model_step(r, s, b, base, off);
        @(posedge clk);
        #1;
        chk("pc", imem_addr, m_pc);
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("fetch_count", fetch_count, m_fc);
        chk("stall_count", {16'd0, stall_count}, 32'(m_sc));
        if (!m_valid) chk("bubble_instr", ifid_instr, 32'h0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic branch(input logic [31:0] base, input logic [15:0] off, input bit s);
        cyc(0, s, 1, base, off);
    endtask

    // Monitor: a new word is presented when IF/ID is valid after an edge without stall.
    initial begin
        bit s_smp;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            s_smp = stall;
            #1;
            if (ifid_valid && !s_smp) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", ifid_instr, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", ifid_instr, e[63:32]);
                    chk("sb_pc_plus1", ifid_pc_plus1, e[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit s, b, r;
        logic [31:0] base;
        logic [15:0] off;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0]  = 32'hACC50000;
        mem[1]  = 32'h8C6A0003;
        mem[2]  = 32'h00A52820;
        mem[15] = 32'h000A5022;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_pp1", ifid_pc_plus1, 32'h0);

        run(1);
        chk("first_instr", ifid_instr, 32'hACC50000);
        chk("first_pp1", ifid_pc_plus1, 32'd1);
        run(2);
        chk("pc_after3", imem_addr, 32'd3);
        chk("fc_after3", fetch_count, 32'd3);

        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("stall_pc", imem_addr, 32'd3);
        chk("stall_hold_instr", ifid_instr, 32'h00A52820);
        chk("stall_cnt2", {16'd0, stall_count}, 32'd2);

        branch(32'd8, 16'd7, 1'b1);
        chk("br_pc", imem_addr, 32'd15);
        chk("br_sc_unchanged", {16'd0, stall_count}, 32'd2);
        run(1);
        chk("br_target_instr", ifid_instr, 32'h000A5022);
        chk("br_target_pp1", ifid_pc_plus1, 32'd16);

        branch(32'd16, 16'hFFF0, 1'b0);
        chk("neg_off_pc", imem_addr, 32'd0);
        run(2);
        branch(32'd0, 16'hFFFF, 1'b0);
        chk("wrap_pc", imem_addr, 32'hFFFFFFFF);
        run(1);
        chk("wrap_halt", {31'd0, halted}, 32'd1);
        cyc(0, 1, 0, 0, 0);

        branch(32'd126, 16'd0, 1'b0);
        run(3);
        chk("end_halt", {31'd0, halted}, 32'd1);
        chk("end_pc", imem_addr, 32'd128);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        branch(32'd0, 16'd0, 1'b0);
        run(2);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            b = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                base = $urandom;
                off  = 16'($urandom);
            end else begin
                base = $urandom_range(0, 140);
                off  = 16'($signed($urandom_range(0, 40)) - 20);
            end
            cyc(r, s, b, base, off);
        end

        run(5);
        cyc(1, 1, 1, 32'd50, 16'd3);
        chk("rst_prio_pc", imem_addr, 32'd0);
        chk("rst_prio_fc", fetch_count, 32'd0);
        chk("rst_prio_sc", {16'd0, stall_count}, 32'd0);

        for (int i = 0; i < 65540; i++) cyc(0, 1, 0, 0, 0);
        chk("sat_sc", {16'd0, stall_count}, 32'h0000FFFF);
        cyc(0, 1, 0, 0, 0);
        chk("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);

        run(4);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
